// File: rtl/fp_vec_pack16_pkg.sv
// Shared types and constants for the fp11 vector packer and sum16.
// Lane layout: lane i of a vector occupies bits [i*EW +: EW].
package fp_vec_pkg;

  localparam int EW         = 11;
  localparam int N_LANES    = 16;
  localparam int LANE_IDX_W = 4;
  localparam int VEC_W      = N_LANES * EW;
  localparam int VLD_W      = LANE_IDX_W + 1;

  typedef logic [EW-1:0] fp11_t;
  typedef fp11_t [N_LANES-1:0] fp_vec_t;

  typedef enum logic {
    EMPTY,
    FILL
  } pack_state_t;

endpackage

// File: rtl/fp_vec_pack16_if.sv
// Push-protocol bundle between element source, packer and sum16.
// master drives element pairs; slave is the packer.
interface fp_vec_pack16_if;
  import fp_vec_pkg::*;

  logic                pushin;
  logic                last;
  fp11_t               a_elem;
  fp11_t               b_elem;
  logic                pushout;
  logic [VEC_W-1:0]    A;
  logic [VEC_W-1:0]    B;
  logic [VLD_W-1:0]    vld_lanes;

  modport master (
    output pushin, last, a_elem, b_elem,
    input  pushout, A, B, vld_lanes
  );

  modport slave (
    input  pushin, last, a_elem, b_elem,
    output pushout, A, B, vld_lanes
  );

endinterface

// File: rtl/fp_vec_pack16.sv
// Serial-to-parallel packer: 16 fp11 pairs -> one A/B vector push.
// Assembly and output registers are split so input never stalls.
module fp_vec_pack16
  import fp_vec_pkg::*;
(
  input logic            clk,
  input logic            reset,
  fp_vec_pack16_if.slave bus
);

  pack_state_t           state_q, state_d;
  logic [LANE_IDX_W-1:0] idx_q, idx_d;
  fp_vec_t               asm_a_q, asm_a_d;
  fp_vec_t               asm_b_q, asm_b_d;
  fp_vec_t               out_a_q, out_a_d;
  fp_vec_t               out_b_q, out_b_d;
  logic [VLD_W-1:0]      vld_q, vld_d;
  logic                  push_q, push_d;
  fp_vec_t               wr_a, wr_b;
  logic                  at_top;
  logic                  close;

  assign at_top = (state_q == FILL) &&
                  (idx_q == LANE_IDX_W'(N_LANES - 1));
  assign close  = bus.pushin & (bus.last | at_top);

  // Assembly contents including the element presented this cycle.
  always_comb begin
    wr_a = asm_a_q;
    wr_b = asm_b_q;
    if (bus.pushin) begin
      wr_a[idx_q] = bus.a_elem;
      wr_b[idx_q] = bus.b_elem;
    end
  end

  // Lane counter, state and output next-state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_a_d = wr_a;
    asm_b_d = wr_b;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    vld_d   = vld_q;
    push_d  = 1'b0;
    if (close) begin
      out_a_d = wr_a;
      out_b_d = wr_b;
      vld_d   = {1'b0, idx_q} + VLD_W'(1);
      push_d  = 1'b1;
      idx_d   = '0;
      state_d = EMPTY;
      asm_a_d = '0;
      asm_b_d = '0;
    end else if (bus.pushin) begin
      idx_d   = idx_q + LANE_IDX_W'(1);
      state_d = FILL;
    end
  end

  // State, assembly and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      asm_a_q <= '0;
      asm_b_q <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      vld_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_a_q <= asm_a_d;
      asm_b_q <= asm_b_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      vld_q   <= vld_d;
      push_q  <= push_d;
    end
  end

  assign bus.pushout   = push_q;
  assign bus.A         = out_a_q;
  assign bus.B         = out_b_q;
  assign bus.vld_lanes = vld_q;

endmodule

// File: doc/fp_vec_pack16.md
Name: fp_vec_pack16

Overview:
- Serial-to-parallel operand packer that sits directly upstream of the sum16 reduction unit.
- Accepts one 11-bit element pair (a, b) per cycle from a streaming source.
- Assembles the pairs into 16-lane 176-bit A/B vectors and issues them to sum16 using the same pushin/pushout push protocol.
- Supports early termination with a `last` marker; unfilled lanes are zero-padded.

Parameters:
- N_LANES, 16, number of lanes per vector.
- EW, 11, element width in bits (fp11 encoding; 11'h000 = +0.0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- pushin  input  1  element pair valid this cycle; no back-pressure, always accepted.
- last  input  1  qualifies pushin; the current element closes the vector.
- a_elem  input  EW  A operand element.
- b_elem  input  EW  B operand element.
- pushout  output  1  one-cycle pulse; A/B/vld_lanes hold a complete vector.
- A  output  N_LANES*EW  packed A vector; lane i at bits [i*EW +: EW].
- B  output  N_LANES*EW  packed B vector, same layout as A.
- vld_lanes  output  5  number of valid lanes in the emitted vector, 1..16.

Behaviour:
- Reset (reset=0, asynchronous): pushout=0, A=0, B=0, vld_lanes=0, lane index=0, assembly registers cleared. Any partial vector is discarded. Outputs remain 0 while reset is held.
- Lane index idx counts 0..N_LANES-1.
  - On pushin=1: a_elem/b_elem are written to assembly lane idx.
- FSM, two states:
  - EMPTY (idx=0): pushin -> FILL with idx=1, unless last is also set.
  - FILL (idx 1..15): pushin advances idx.
- Close condition: pushin=1 AND (idx==N_LANES-1 OR last=1).
  - Next edge: the output registers load the assembly contents, including the current element.
  - vld_lanes = idx+1.
  - pushout=1 for exactly that one cycle.
  - idx returns to 0; the assembly register is cleared to zero in the same edge.
- Latency: pushout asserts 1 cycle after the closing element is presented.
- Throughput: 1 element per cycle sustained. The assembly and output registers are separate, so a pushin in the cycle of, or right after, pushout goes to lane 0 of the next vector with no bubble or loss.
- Zero padding: lanes >= vld_lanes in A and B are 11'h000.
- Output hold: A, B and vld_lanes stay stable after pushout until the next close. pushout is 0 otherwise.
- pushin=0: no state change. last without pushin is ignored. Idle gaps of any length between elements are allowed.
- last on lane 15 (idx==15 with last=1): one single close, vld_lanes=16, no extra empty vector.
- last on lane 0: 1-lane vector, vld_lanes=1.
- No arithmetic or element modification; the packer is a pure bit transport.

Decomposition:
- Shared package fp_vec_pkg:
  - constants EW=11, N_LANES=16, LANE_IDX_W=4, VEC_W=176.
  - typedef fp11_t (logic [EW-1:0]).
  - typedef fp_vec_t (packed array [N_LANES] of fp11_t).
  - enum pack_state_t {EMPTY, FILL}.
  - The same package is shared by sum16 and its bench.
- No sub-module; the lane write decode, counter and FSM are small enough for a single module.

Test Plan:
- 16 contiguous pushes, a_elem=i, b_elem=11'h7FF-i for i=0..15 -> pushout pulses 1 cycle after the 16th push. Lane i of A = i, lane i of B = 11'h7FF-i, vld_lanes=16.
- 3 pushes a=11'h3C0,11'h3C1,11'h3C2 with last on the 3rd -> pushout after the 3rd. A[32:0] = {3C2,3C1,3C0}, A[175:33]=0, B similarly padded, vld_lanes=3.
- 32 back-to-back pushes with values 0..31 -> exactly two pushout pulses 16 cycles apart. The second vector holds 16..31, no element lost or duplicated, and A holds the first vector unchanged between the pulses.
- The same 16 elements with random pushin gaps (0-5 idle cycles) -> vector bit-identical to the contiguous case. pushout still asserts 1 cycle after the last element.
- reset driven low after 5 pushes, then released, then 16 pushes of 11'h155 -> pushout/A/B/vld_lanes=0 during reset. After release, a single vector with all 16 lanes = 11'h155; no stale lanes from the aborted vector.
- last on the 16th element, and separately last on the 1st element -> one pulse only, with vld_lanes=16 and vld_lanes=1 respectively. In the 1-lane case only A[10:0] and B[10:0] are non-zero.
